// File: rtl/uart_tx_sched.sv
// MiniUART transmit scheduler: round-robin byte arbiter into a small FIFO, drained by a
// WISHBONE master FSM that polls LSR, writes DATA and applies divisor updates.
module uart_tx_sched #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned AW     = 2,
   parameter logic [2:0]  A_DATA = 3'd0,
   parameter logic [2:0]  A_LSR  = 3'd1,
   parameter logic [2:0]  A_DIVR = 3'd2,
   parameter logic [2:0]  A_DIVT = 3'd3,
   parameter int unsigned GUARD  = 2
) (
   input  logic        CLK_I,
   input  logic        RST_I,
   input  logic        req0,
   input  logic [7:0]  dat0,
   output logic        gnt0,
   input  logic        req1,
   input  logic [7:0]  dat1,
   output logic        gnt1,
   input  logic        cfg_req,
   input  logic [15:0] cfg_divr,
   input  logic [15:0] cfg_divt,
   output logic        cfg_ack,
   output logic [2:0]  ADD_O,
   output logic [31:0] DAT_O,
   input  logic [31:0] DAT_I,
   output logic        STB_O,
   output logic        WE_O,
   input  logic        ACK_I,
   output logic        busy
);

   localparam int unsigned GW = $clog2(GUARD + 2);

   typedef enum logic [2:0] {
      StIdle, StCfgR, StCfgT, StPoll, StGap, StWrData, StHold
   } state_e;

   state_e          state_q, state_d;
   logic [7:0]      mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [AW:0]     count_q;
   logic            rr_q;    // 1: requester 1 wins the next tie
   logic            drop_q;  // forces STB_O low for the cycle after an ACK
   logic [GW-1:0]   guard_q, guard_d;
   logic            full, empty, push, pop, stb, acc;
   logic [7:0]      push_dat;

   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);

   // Grants are gated by reset so every output reads 0 while RST_I is low.
   assign gnt0     = RST_I & ~full & req0 & (~req1 | ~rr_q);
   assign gnt1     = RST_I & ~full & req1 & (~req0 | rr_q);
   assign push     = gnt0 | gnt1;
   assign push_dat = gnt0 ? dat0 : dat1;

   assign stb   = ((state_q == StCfgR) | (state_q == StCfgT) | (state_q == StPoll) |
                   (state_q == StWrData)) & ~drop_q;
   assign acc   = stb & ACK_I;
   assign pop   = (state_q == StWrData) & acc;
   assign STB_O = stb;
   assign busy  = ~empty | (state_q != StIdle);

   always_ff @(posedge CLK_I) begin
      if (push) mem_q[wr_ptr_q] <= push_dat;
   end

   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         rr_q     <= 1'b0;
         drop_q   <= 1'b0;
         guard_q  <= '0;
         state_q  <= StIdle;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
            rr_q     <= gnt0;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
         if (push && !pop)      count_q <= count_q + (AW+1)'(1);
         else if (pop && !push) count_q <= count_q - (AW+1)'(1);
         drop_q  <= acc;
         guard_q <= guard_d;
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      guard_d = guard_q;
      ADD_O   = 3'd0;
      WE_O    = 1'b0;
      DAT_O   = 32'd0;
      cfg_ack = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (cfg_req)     state_d = StCfgR;
            else if (!empty) state_d = StPoll;
         end
         StCfgR: begin
            ADD_O = A_DIVR;
            WE_O  = 1'b1;
            DAT_O = {16'd0, cfg_divr};
            if (acc) state_d = StCfgT;
         end
         StCfgT: begin
            ADD_O = A_DIVT;
            WE_O  = 1'b1;
            DAT_O = {16'd0, cfg_divt};
            if (acc) begin
               cfg_ack = 1'b1;
               state_d = StIdle;
            end
         end
         StPoll: begin
            ADD_O = A_LSR;
            if (acc) state_d = DAT_I[5] ? StWrData : StGap;
         end
         StGap: state_d = cfg_req ? StIdle : StPoll;
         StWrData: begin
            ADD_O = A_DATA;
            WE_O  = 1'b1;
            DAT_O = {24'd0, mem_q[rd_ptr_q]};
            if (acc) begin
               guard_d = GW'(GUARD);
               state_d = StHold;
            end
         end
         StHold: begin
            // Covers the UART's delayed busy flag so the next poll never sees stale idle.
            if (guard_q == '0) state_d = StIdle;
            else               guard_d = guard_q - GW'(1);
         end
         default: state_d = StIdle;
      endcase
   end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Transmit scheduler for the MiniUART. Two byte requesters share one UART through round-robin arbitration into a small FIFO. A bus-master FSM drains the FIFO into the UART over its WISHBONE slave port: it polls LSR for transmitter idle, then writes DATA. It also applies divisor (baud) reconfiguration on request, ahead of queued data.

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2
AW, 2, FIFO pointer width; log2(DEPTH)
A_DATA, 3'd0, UART DATA register offset (ADD[4:2])
A_LSR, 3'd1, UART LSR register offset
A_DIVR, 3'd2, UART DIVR register offset
A_DIVT, 3'd3, UART DIVT register offset
GUARD, 2, cycles to wait after a DATA write before the next LSR poll

Ports:
CLK_I  in  1  clock, single domain
RST_I  in  1  reset, asynchronous, active-low (asserted when 0)
req0  in  1  requester 0 has a byte
dat0  in  8  requester 0 byte
gnt0  out  1  1-cycle pulse: dat0 accepted this cycle
req1  in  1  requester 1 has a byte
dat1  in  8  requester 1 byte
gnt1  out  1  1-cycle pulse: dat1 accepted
cfg_req  in  1  level: apply new divisors; held until cfg_ack
cfg_divr  in  16  new DIVR value
cfg_divt  in  16  new DIVT value
cfg_ack  out  1  1-cycle pulse: both divisors written
ADD_O  out  3  UART address [4:2]
DAT_O  out  32  UART write data
DAT_I  in  32  UART read data
STB_O  out  1  UART strobe
WE_O  out  1  UART write enable
ACK_I  in  1  UART acknowledge
busy  out  1  FIFO non-empty or FSM not in IDLE

Behaviour:
- Reset (RST_I=0, async) forces the following: all outputs 0, FIFO empty, RR pointer selects requester 0, FSM in IDLE, guard counter 0.
- Arbiter:
  - A grant occurs only when the FIFO is not full. At most one grant per cycle.
  - One requester active: that requester is granted.
  - Both active: the requester not granted last time wins. Last-winner is updated only on a grant.
  - gnt is a registered-free combinational pulse in the accepting cycle. The byte is written to the FIFO tail at the clock edge.
  - Requesters must hold req/dat until gnt.
- FIFO: push from the arbiter, pop in the WR_DATA ACK cycle. Simultaneous push and pop when full is not allowed (the push is blocked by full). Simultaneous push and pop otherwise keeps the count unchanged. Pointers wrap modulo DEPTH.
- Bus rules:
  - Every access holds STB_O, ADD_O, WE_O and DAT_O stable until the cycle ACK_I=1, then drops STB_O for at least one cycle.
  - A read samples DAT_I in the ACK cycle.
  - DAT_O is zero-extended.
- FSM:
  - IDLE: cfg_req=1 goes to CFG_R (cfg has priority). Otherwise FIFO non-empty goes to POLL.
  - CFG_R: write A_DIVR with cfg_divr. On ACK go to CFG_T.
  - CFG_T: write A_DIVT with cfg_divt. On ACK pulse cfg_ack and go to IDLE.
  - POLL: read A_LSR. On ACK, DAT_I[5]=1 (tx idle) goes to WR_DATA. DAT_I[5]=0 goes to GAP (1 idle cycle), then POLL. cfg_req seen in GAP goes to IDLE instead.
  - WR_DATA: write A_DATA with FIFO head. On ACK, pop, load the guard counter with GUARD, and go to HOLD.
  - HOLD: count down to 0, then go to IDLE. HOLD covers the UART's delayed busy flag, so a stale idle status is never read.
- Minimum per-byte bus latency with zero-wait ACK: POLL, GAP-free WR_DATA, each 1 cycle, plus idle gaps. STB_O is deasserted at least 1 cycle between accesses.
- cfg_req during a data sequence is serviced only from IDLE or GAP. A byte write in progress always completes first.
- Reset mid-access: STB_O drops immediately. The FIFO contents are lost.

Test Plan:
- Single byte: req0 with 0x41, ACK_I=STB_O, LSR[5]=1 -> gnt0 pulses. Then an LSR read at A_LSR, then a write to A_DATA with DAT_O=0x00000041. FIFO empties, busy falls after GUARD+1 cycles.
- Contention: req0 and req1 both held with 0x10 and 0x20 for 4 bytes -> grants alternate 0,1,0,1. UART writes appear in order 0x10,0x20,0x10,0x20.
- Full FIFO: LSR[5]=0 forced, req0 held -> exactly DEPTH(=4) gnt0 pulses, then gnt0 stays 0. Polls repeat with a GAP cycle between them. Releasing LSR[5]=1 drains all 4 bytes.
- Config priority: FIFO holding 2 bytes while the FSM is in GAP and cfg_req=1 with divr 0x0A2C, divt 0x0A2C -> DIVR write, DIVT write, one cfg_ack pulse, then the bytes are sent.
- Wait states: ACK_I delayed 3 cycles on each access -> STB_O, ADD_O and DAT_O stay stable all 3 cycles. No duplicate DATA writes.
- Async reset asserted while STB_O=1 in WR_DATA -> all outputs 0 with no clock edge. After release, IDLE with FIFO empty and no bus activity.
